axi_llc_data_way_arb: RTL
=========================

# axi_llc_data_way_arb

Request arbiter directly upstream of a single data way: merges the SRAM access requests of the cache units (evict, refill, write-channel, read-channel) into the one request stream that feeds the data way's input handshake. Round-robin arbitration with a burst lock, so a multi-beat cache-line access from one unit is never interleaved with another unit's beats. Registered output stage; full throughput of one request per cycle. The granted unit index travels with the request so the data way can tag its read response.

## Interface
Parameters:
- `NumUnits`, 4: number of requesting units; index 0..NumUnits-1 equals the `cache_unit_e` encoding.
- `AddrWidth`, 10: SRAM word address width (line index + block offset).
- `DataWidth`, 64: data width; must be a multiple of 8.
- `UnitIdxWidth`, `$clog2(NumUnits)` (min 1): width of the unit index.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  NumUnits  per-unit request valid.
- `req_ready_o`  out  NumUnits  per-unit request accepted.
- `req_addr_i`  in  NumUnits×AddrWidth  per-unit SRAM address.
- `req_we_i`  in  NumUnits  per-unit write enable.
- `req_data_i`  in  NumUnits×DataWidth  per-unit write data.
- `req_strb_i`  in  NumUnits×DataWidth/8  per-unit byte enables.
- `req_last_i`  in  NumUnits  last beat of the unit's burst; releases the lock.
- `out_valid_o`  out  1  registered request valid, to the data way.
- `out_ready_i`  in  1  data way ready.
- `out_unit_o`  out  UnitIdxWidth  index of the unit that issued the request.
- `out_addr_o`, `out_we_o`, `out_data_o`, `out_strb_o`  out  AddrWidth/1/DataWidth/DataWidth/8  registered request fields.

## Operation
- Output register: `space = ~out_valid_q | out_ready_i`. A handshake on unit k (`req_valid_i[k] & req_ready_o[k]`) loads all output fields and `out_unit_o = k` and sets `out_valid_q`. If there is no input handshake and `out_ready_i` is high, `out_valid_q` is cleared.
- Grant (combinational):
  - Unlocked: the first valid unit scanning k = rr_q, rr_q+1, … mod NumUnits.
  - Locked: only `lock_unit_q`, and only if its valid is high. No other unit is granted even when the locked unit is idle.
- `req_ready_o[k] = grant[k] & space`. At most one bit is set. Ready never depends on any other unit's ready.
- Lock FSM, states UNLOCKED/LOCKED:
  - UNLOCKED → LOCKED on a handshake with `req_last_i = 0`; `lock_unit_q = k`.
  - LOCKED → UNLOCKED on a handshake from `lock_unit_q` with `req_last_i = 1`.
  - A handshake with `last = 1` in UNLOCKED keeps the FSM in UNLOCKED.
- Round-robin pointer: on every handshake with `req_last_i = 1` from unit k, `rr_q = (k+1) mod NumUnits`, with wrap-around. The pointer does not move on non-last beats.
- Protocol rules, checked by assertions and not corrected by the RTL:
  - Once `req_valid_i[k]` is raised it stays high with stable fields until accepted.
  - `out_*` fields are stable while `out_valid_o & ~out_ready_i`.

## Timing
- Reset, synchronous, while `rst_i` is high at a clock edge:
  - `out_valid_o = 0`, `out_unit_o = 0`, `out_addr_o/we/data/strb = 0`.
  - Lock FSM = UNLOCKED, `rr_q = 0`.
  - `req_ready_o` is 0 during reset cycles.
- Reset mid-burst drops the lock and any held output. Units must restart their bursts.
- Latency: input handshake in cycle t gives `out_valid_o` in cycle t+1.
- Throughput: one request per cycle while `out_ready_i` stays high. There is no bubble on lock transitions or pointer updates.
- Back-pressure: `out_ready_i = 0` with the register full forces all `req_ready_o` to 0 in that same cycle.
- Simultaneous dequeue and enqueue: a new handshake in the same cycle that the output is consumed overwrites the register, and `out_valid_o` stays 1.
- Single-beat requests (`last = 1`) never lock. A burst of length 1 is identical to a single request.
- All valids low: no grant, and the pointer and lock are unchanged.

## Test plan
- Reset then a single request: unit 2 with addr 0x1A, we=0, last=1, one cycle → `out_valid_o = 1` the next cycle with `out_unit_o = 2`, addr 0x1A; `rr_q = 3` afterwards.
- Round-robin fairness: all 4 units hold valid with last=1 continuously and `out_ready_i = 1` → grant order 0,1,2,3,0,1… with one output per cycle and no bubbles.
- Burst lock: unit 1 sends a 4-beat burst (last on beat 4) while unit 0 is valid throughout → output units 1,1,1,1 then 0; unit 0 sees ready only after unit 1's last beat.
- Locked unit idles: unit 3 is locked, its valid drops for 2 cycles, units 0 and 1 are valid → no grants for 2 cycles; unit 3 resumes and completes, then unit 0 is granted.
- Back-pressure: `out_ready_i = 0` for 3 cycles with the register full → all `req_ready_o = 0` and the output fields are stable; with `out_ready_i = 1` and the next request pending, `out_valid_o` stays 1 and the new data appears the next cycle.
- Reset mid-burst: assert `rst_i` during beat 2 of unit 2's burst → the next cycle has `out_valid_o = 0` and the FSM UNLOCKED; after reset, with units 0 and 2 valid, unit 0 is granted first (`rr_q = 0`).

Source files
------------

// File: rtl/axi_llc_data_way_arb_if.sv
// ============================================================================
// axi_llc_data_way_arb_if
// ----------------------------------------------------------------------------
// Purpose : Bundles the request-side and data-way-side handshakes of the
//           data way arbiter.
//           The slave modport is the arbiter's view.
//           The master modport is the view of the units plus the data way,
//           as driven by a test environment.
// Signals :
//   req_valid_i/ready_o   per-unit request handshake
//   req_addr_i            per-unit SRAM word address
//   req_we_i              per-unit write enable
//   req_data_i            per-unit write data
//   req_strb_i            per-unit byte enables
//   req_last_i            per-unit last-beat marker
//   out_valid_o/ready_i   merged request handshake towards the data way
//   out_unit_o            granted unit index
//   out_addr_o, out_we_o,
//   out_data_o, out_strb_o  registered request fields
// ============================================================================
interface axi_llc_data_way_arb_if #(
    parameter int NumUnits     = 4,
    parameter int AddrWidth    = 10,
    parameter int DataWidth    = 64,
    parameter int UnitIdxWidth = (NumUnits > 1) ? $clog2(NumUnits) : 1
);
    logic [NumUnits-1:0]                    req_valid_i;
    logic [NumUnits-1:0]                    req_ready_o;
    logic [NumUnits-1:0][AddrWidth-1:0]     req_addr_i;
    logic [NumUnits-1:0]                    req_we_i;
    logic [NumUnits-1:0][DataWidth-1:0]     req_data_i;
    logic [NumUnits-1:0][DataWidth/8-1:0]   req_strb_i;
    logic [NumUnits-1:0]                    req_last_i;

    logic                                   out_valid_o;
    logic                                   out_ready_i;
    logic [UnitIdxWidth-1:0]                out_unit_o;
    logic [AddrWidth-1:0]                   out_addr_o;
    logic                                   out_we_o;
    logic [DataWidth-1:0]                   out_data_o;
    logic [DataWidth/8-1:0]                 out_strb_o;

    modport slave (
        input  req_valid_i, req_addr_i, req_we_i, req_data_i, req_strb_i,
               req_last_i, out_ready_i,
        output req_ready_o, out_valid_o, out_unit_o, out_addr_o, out_we_o,
               out_data_o, out_strb_o
    );

    modport master (
        output req_valid_i, req_addr_i, req_we_i, req_data_i, req_strb_i,
               req_last_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_unit_o, out_addr_o, out_we_o,
               out_data_o, out_strb_o
    );
endinterface

// File: rtl/axi_llc_data_way_arb.sv
// ============================================================================
// axi_llc_data_way_arb
// ----------------------------------------------------------------------------
// Purpose : Merges the SRAM requests of the cache units into the single
//           request stream of one data way.
//           - Arbitration is round-robin.
//           - A multi-beat burst locks the grant to its unit until the last
//             beat, so the beats of one burst are never interleaved.
//           - The output stage is registered and sustains one request per
//             cycle.
//           - The granted unit index travels with the request.
// Ports   :
//   clk_i   clock, rising edge
//   rst_i   synchronous active-high reset
//   bus     axi_llc_data_way_arb_if.slave; carries the per-unit request
//           handshakes and the registered output handshake
// ============================================================================
module axi_llc_data_way_arb #(
    parameter int NumUnits     = 4,
    parameter int AddrWidth    = 10,
    parameter int DataWidth    = 64,
    parameter int UnitIdxWidth = (NumUnits > 1) ? $clog2(NumUnits) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    axi_llc_data_way_arb_if.slave   bus
);
    localparam int StrbWidth = DataWidth / 8;
    localparam int SumWidth  = UnitIdxWidth + 1;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    lock_state_e                r_state;
    lock_state_e                w_state_nxt;
    logic [UnitIdxWidth-1:0]    r_lock_unit;
    logic [UnitIdxWidth-1:0]    r_rr;

    logic                       r_out_valid;
    logic [UnitIdxWidth-1:0]    r_out_unit;
    logic [AddrWidth-1:0]       r_out_addr;
    logic                       r_out_we;
    logic [DataWidth-1:0]       r_out_data;
    logic [StrbWidth-1:0]       r_out_strb;

    logic [NumUnits-1:0]        w_grant;
    logic [UnitIdxWidth-1:0]    w_gnt_idx;
    logic [SumWidth-1:0]        w_scan_sum;
    logic [UnitIdxWidth-1:0]    w_scan_idx;
    logic [NumUnits-1:0]        w_ready;
    logic                       w_space;
    logic                       w_hs;
    logic                       w_hs_last;

    // Grant selection.
    // While unlocked, the scan runs from the farthest offset back to rr_q, so
    // the last match written wins.
    // That is the first valid unit at or after rr_q.
    // While locked, only the locked unit may be granted, even when it is idle.
    always_comb begin
        w_grant    = '0;
        w_gnt_idx  = '0;
        w_scan_sum = '0;
        w_scan_idx = '0;
        if (r_state == LOCKED) begin
            w_gnt_idx            = r_lock_unit;
            w_grant[r_lock_unit] = bus.req_valid_i[r_lock_unit];
        end else begin
            for (int i = NumUnits - 1; i >= 0; i--) begin
                w_scan_sum = {1'b0, r_rr} + SumWidth'(i);
                if (w_scan_sum >= SumWidth'(NumUnits)) begin
                    w_scan_sum = w_scan_sum - SumWidth'(NumUnits);
                end
                w_scan_idx = w_scan_sum[UnitIdxWidth-1:0];
                if (bus.req_valid_i[w_scan_idx]) begin
                    w_grant             = '0;
                    w_grant[w_scan_idx] = 1'b1;
                    w_gnt_idx           = w_scan_idx;
                end
            end
        end
    end

    // The output register can take a new request when it is empty or being
    // drained this cycle.
    assign w_space   = ~r_out_valid | bus.out_ready_i;
    assign w_ready   = (rst_i || !w_space) ? '0 : w_grant;
    assign w_hs      = |w_ready;
    assign w_hs_last = bus.req_last_i[w_gnt_idx];

    // Lock FSM next state.
    // In LOCKED a handshake can only come from the locked unit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            UNLOCKED: if (w_hs && !w_hs_last) w_state_nxt = LOCKED;
            LOCKED:   if (w_hs &&  w_hs_last) w_state_nxt = UNLOCKED;
            default:  w_state_nxt = UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= UNLOCKED;
            r_lock_unit <= '0;
            r_rr        <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == UNLOCKED && w_hs && !w_hs_last) begin
                r_lock_unit <= w_gnt_idx;
            end
            // The pointer only advances when a burst (or single beat) ends.
            if (w_hs && w_hs_last) begin
                r_rr <= (w_gnt_idx == UnitIdxWidth'(NumUnits - 1)) ? '0
                                                                    : w_gnt_idx + 1'b1;
            end
        end
    end

    // Output register.
    // A new handshake overwrites the register even in the cycle the register
    // drains, so there is no bubble.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_out_valid <= 1'b0;
            r_out_unit  <= '0;
            r_out_addr  <= '0;
            r_out_we    <= 1'b0;
            r_out_data  <= '0;
            r_out_strb  <= '0;
        end else if (w_hs) begin
            r_out_valid <= 1'b1;
            r_out_unit  <= w_gnt_idx;
            r_out_addr  <= bus.req_addr_i[w_gnt_idx];
            r_out_we    <= bus.req_we_i[w_gnt_idx];
            r_out_data  <= bus.req_data_i[w_gnt_idx];
            r_out_strb  <= bus.req_strb_i[w_gnt_idx];
        end else if (bus.out_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.req_ready_o = w_ready;
    assign bus.out_valid_o = r_out_valid;
    assign bus.out_unit_o  = r_out_unit;
    assign bus.out_addr_o  = r_out_addr;
    assign bus.out_we_o    = r_out_we;
    assign bus.out_data_o  = r_out_data;
    assign bus.out_strb_o  = r_out_strb;

    // Protocol checks.
    // A pending request must hold its valid and fields until accepted.
    // A stalled output must not change.
    for (genvar k = 0; k < NumUnits; k++) begin : g_req_chk
        a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (bus.req_valid_i[k] && !bus.req_ready_o[k]) |=>
            (bus.req_valid_i[k] && $stable(bus.req_addr_i[k]) &&
             $stable(bus.req_we_i[k]) && $stable(bus.req_data_i[k]) &&
             $stable(bus.req_strb_i[k]) && $stable(bus.req_last_i[k])));
    end

    a_out_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (bus.out_valid_o && !bus.out_ready_i) |=>
        (bus.out_valid_o && $stable(bus.out_unit_o) && $stable(bus.out_addr_o) &&
         $stable(bus.out_we_o) && $stable(bus.out_data_o) && $stable(bus.out_strb_o)));

    a_ready_onehot: assert property (@(posedge clk_i) $onehot0(bus.req_ready_o));

endmodule
